// File: rtl/tdp_ram_pkg.sv
// Shared types and constants for the parametrised true dual-port RAM.
// Optional output pipeline stage is selected with TDP_RAM_OUT_REG_EN (see tdp_ram_param).
package tdp_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } init_state_t;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/tdp_ram_init_fsm.sv
// Post-reset memory clear sequencer: sweeps every address once writing zero,
// then holds READY (init_done=1) until the next reset.
//
// state | meaning
// ------+-----------------------------------------------------------
// CLEAR | writing 0 to mem[clr_cnt]; port requests are ignored
// READY | clear finished, normal port operation
module tdp_ram_init_fsm
    import tdp_ram_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_done,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    init_state_t       state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        init_done = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = READY;
                end
            end
            READY: begin
                init_done = 1'b1;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign clr_addr = clr_cnt_q;

endmodule

// File: rtl/tdp_ram_param.sv
// Parametrised single-clock true dual-port RAM with collision flag and
// post-reset clear. Define TDP_RAM_OUT_REG_EN for an extra output register stage.
module tdp_ram_param
    import tdp_ram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int RDW_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_done,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    output logic              collision
);

    localparam int DEPTH       = 2 ** ADDR_W;
    localparam bit WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              port_ok;
    logic              a_wr, b_wr, a_rd, b_rd, same_addr, b_wr_keep;

    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
    logic              a_rvalid_q, b_rvalid_q, collision_q;

    tdp_ram_init_fsm #(
        .ADDR_W(ADDR_W)
    ) u_init_fsm (
        .clk      (clk),
        .rst      (rst),
        .init_done(init_done),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A reset edge arriving while READY must not let a port write slip through.
    assign port_ok   = init_done & ~rst;
    assign a_wr      = port_ok & a_en & a_we;
    assign b_wr      = port_ok & b_en & b_we;
    assign a_rd      = port_ok & a_en & ~a_we;
    assign b_rd      = port_ok & b_en & ~b_we;
    assign same_addr = (a_addr == b_addr);
    assign b_wr_keep = b_wr & ~(a_wr & same_addr);

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            if (a_wr) begin
                mem[a_addr] <= a_wdata;
            end
            if (b_wr_keep) begin
                mem[b_addr] <= b_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            a_rvalid_q  <= a_rd;
            b_rvalid_q  <= b_rd;
            collision_q <= a_wr & b_wr & same_addr;
            // A reader only ever faces a write from the other port, never its own.
            if (a_rd) begin
                a_rdata_q <= (WRITE_FIRST && b_wr && same_addr) ? b_wdata : mem[a_addr];
            end
            if (b_rd) begin
                b_rdata_q <= (WRITE_FIRST && a_wr && same_addr) ? a_wdata : mem[b_addr];
            end
        end
    end

`ifdef TDP_RAM_OUT_REG_EN
    logic [DATA_W-1:0] a_rdata_p, b_rdata_p;
    logic              a_rvalid_p, b_rvalid_p, collision_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata_p   <= '0;
            b_rdata_p   <= '0;
            a_rvalid_p  <= 1'b0;
            b_rvalid_p  <= 1'b0;
            collision_p <= 1'b0;
        end else begin
            a_rdata_p   <= a_rdata_q;
            b_rdata_p   <= b_rdata_q;
            a_rvalid_p  <= a_rvalid_q;
            b_rvalid_p  <= b_rvalid_q;
            collision_p <= collision_q;
        end
    end

    assign a_rdata   = a_rdata_p;
    assign b_rdata   = b_rdata_p;
    assign a_rvalid  = a_rvalid_p;
    assign b_rvalid  = b_rvalid_p;
    assign collision = collision_p;
`else
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign collision = collision_q;
`endif

endmodule

// File: doc/tdp_ram_param.md
Name: tdp_ram_param

Overview:
- Parametrised, single-clock, true dual-port RAM with two independent read/write ports (A, B).
- Successor to the fixed 16x8 dual-port RAM.
- Replaces bidirectional data pins with separate write-data and read-data buses, and adds per-port read-valid, defined collision and read-during-write behaviour, and a post-reset memory clear sequence.
- Used as the shared buffer between two producers/consumers in the same clock domain.

Parameters:
- DATA_W, 8, width of each word in bits (>=1).
- ADDR_W, 4, address width; depth is a derived local constant, DEPTH = 2**ADDR_W.
- RDW_MODE, 0, same-address read-during-write from the other port: 0 = read-first (old data), 1 = write-first (new data).

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- init_done  out  1  high once the memory clear sequence has completed.
- a_en  in  1  port A request strobe.
- a_we  in  1  port A write (1) / read (0); qualified by a_en.
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_rdata  out  DATA_W  port A read data.
- a_rvalid  out  1  port A read data valid (one-cycle pulse).
- b_en, b_we, b_addr, b_wdata, b_rdata, b_rvalid: identical to port A, for port B.
- collision  out  1  pulse: both ports wrote the same address in the same cycle.

Behaviour:
- Reset (rst=1 at posedge): a_rdata=0, b_rdata=0, a_rvalid=0, b_rvalid=0, collision=0, init_done=0; state<=CLEAR, clear counter<=0.
- FSM states:
  - CLEAR: writes 0 to address clr_cnt each cycle, clr_cnt increments. Transitions to READY after writing DEPTH-1, so the clear takes exactly DEPTH cycles after rst deasserts. init_done rises on the first READY cycle.
  - READY: normal operation; remains here until rst.
- During CLEAR all port requests are ignored: no writes, rvalid stays 0.
- Reset asserted mid-CLEAR or in READY restarts CLEAR from address 0. Memory contents are not otherwise guaranteed.
- Write: en=1, we=1 at posedge -> mem[addr]<=wdata. No rvalid pulse; rdata holds its previous value.
- Read: en=1, we=0 at posedge -> rdata = mem[addr] and rvalid=1 on the next cycle (latency 1). rvalid=0 in cycles with no accepted read. rdata holds its last value when idle.
- Simultaneous events, READY only:
  - Both write, same address: port A data is stored, port B write is dropped, collision=1 next cycle.
  - Both write, different addresses: both stored, no collision.
  - One writes, other reads same address: reader returns old data if RDW_MODE=0, the writer's data if RDW_MODE=1. No collision flag.
  - Both read, same address: both return the same data.
- A port's own write and read never coincide (we selects one).
- Address arithmetic is unsigned. Every ADDR_W value is valid, so there is no out-of-range case.
- collision is a registered one-cycle pulse and is 0 during CLEAR.

Optional Feature:
- Macro TDP_RAM_OUT_REG_EN.
- Defined: adds one output pipeline register per port on rdata and rvalid. Read latency becomes 2 cycles, and collision is delayed to align (2 cycles). Reset clears the extra stage to 0.
- Undefined: read latency is 1 cycle, as specified above.

Decomposition:
- Package tdp_ram_pkg holds:
  - FSM state type {CLEAR, READY};
  - RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1 constants.
- One sub-module, tdp_ram_init_fsm:
  - contains the CLEAR/READY state, clr_cnt and init_done;
  - outputs the clear write enable and address to the array.
- Top level owns the memory array, port arbitration, RDW muxing and collision logic.

Test Plan (DATA_W=8, ADDR_W=4, option off unless stated):
- Reset clear: pulse rst, then hold a_en=1, a_we=1, a_addr=3, a_wdata=8'hFF during the 16 clear cycles -> init_done rises 16 cycles after rst falls, and a read of addr 3 returns 8'h00 with a_rvalid after 1 cycle.
- Independent ports: A writes i to even addrs, B writes i+8'h80 to odd addrs 0..15; then read all addresses alternating ports -> each rdata matches, rvalid pulses 1 cycle after each read.
- Write collision: both write addr 5, A=8'h11, B=8'h22 -> collision=1 the next cycle; a subsequent read of 5 returns 8'h11.
- Read-during-write: mem[7]=8'hAA; A writes 8'h55 to 7 while B reads 7 -> b_rdata=8'hAA with RDW_MODE=0, 8'h55 with RDW_MODE=1.
- Reset mid-operation: assert rst during READY after writes -> outputs 0, init_done drops, and all addresses read 8'h00 after the new clear.
- TDP_RAM_OUT_REG_EN defined: read addr 2 holding 8'h3C -> a_rvalid and a_rdata=8'h3C appear 2 cycles after the request; collision is also 2 cycles late.
